// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO control-register access arbiter:
// bus op encoding, PIO s1 register addresses and FSM state codes.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // PIO register targeted by each op; READ and WRITE both use the data register.
    function automatic logic [2:0] op_addr(input op_e op);
        logic [2:0] addr;
        case (op)
            OP_SET:   addr = ADDR_SET;
            OP_CLEAR: addr = ADDR_CLR;
            default:  addr = ADDR_DATA;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/pio_ctrl_access_arbiter_if.sv
// Avalon-MM link between the arbiter (master) and the PIO s1 slave.
interface pio_ctrl_access_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic [2:0]        avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at/after the pointer wins; the pointer
// moves one past the winner whenever a request is accepted.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        grant_c = '0;
        idx_c   = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found         = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && (|req)) begin
            ptr <= (idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : idx_c + 1'b1;
        end
    end

endmodule

// File: rtl/pio_ctrl_access_arbiter.sv
// Shares one PIO control-register slave between NUM_REQ requesters, one bus op at a time,
// and mirrors the PIO output register. `define STATUS_POLL_EN adds background in_port polling.
module pio_ctrl_access_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 32
`ifdef STATUS_POLL_EN
    ,
    parameter int unsigned POLL_DIV = 1024
`endif
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic [DATA_W-1:0]         ctrl_shadow,
    pio_ctrl_access_arbiter_if.master avm,
    output logic [DATA_W-1:0]         status_q,
    output logic                      status_chg
);
    import pio_arb_pkg::*;

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ST_W-1:0]    state, state_d;
    op_e                op_q, op_d;
    logic               poll_q, poll_d;
    logic               poll_pending;
    logic               poll_take_c;
    logic [NUM_REQ-1:0] arb_grant_c;
    logic [IDX_W-1:0]   arb_idx_c;
    op_e                sel_op_c;
    logic [DATA_W-1:0]  sel_wdata_c;
    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic [DATA_W-1:0]  rdata_d, shadow_d, status_d;
    logic               chg_d;
    logic [2:0]         addr_d;
    logic               cs_d, wn_d;
    logic [DATA_W-1:0]  wd_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (state == ST_IDLE),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c)
    );

    assign sel_op_c    = op_e'(req_op[2*arb_idx_c +: 2]);
    assign sel_wdata_c = req_wdata[DATA_W*arb_idx_c +: DATA_W];
    assign poll_take_c = (state == ST_IDLE) && (req == '0) && poll_pending;

`ifdef STATUS_POLL_EN
    localparam int unsigned CNT_W = $clog2(POLL_DIV);

    logic [CNT_W-1:0] poll_cnt;
    logic             poll_wrap_c;

    assign poll_wrap_c = (poll_cnt == CNT_W'(POLL_DIV - 1));

    // A wrap while a poll is already pending simply leaves it pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else begin
            poll_cnt <= poll_wrap_c ? '0 : poll_cnt + 1'b1;
            if (poll_wrap_c)
                poll_pending <= 1'b1;
            else if (poll_take_c)
                poll_pending <= 1'b0;
        end
    end
`else
    assign poll_pending = 1'b0;
`endif

    // Next-state and next-output logic; bus is idle everywhere except the XFER cycle.
    always_comb begin
        state_d  = state;
        op_d     = op_q;
        poll_d   = poll_q;
        gnt_d    = gnt;
        done_d   = '0;
        rdata_d  = rdata;
        shadow_d = ctrl_shadow;
        status_d = status_q;
        chg_d    = 1'b0;
        addr_d   = ADDR_DATA;
        cs_d     = 1'b0;
        wn_d     = 1'b1;
        wd_d     = '0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_XFER;
                    op_d    = sel_op_c;
                    poll_d  = 1'b0;
                    gnt_d   = arb_grant_c;
                    addr_d  = op_addr(sel_op_c);
                    cs_d    = 1'b1;
                    wn_d    = (sel_op_c == OP_READ);
                    wd_d    = (sel_op_c == OP_READ) ? '0 : sel_wdata_c;
                end else if (poll_take_c) begin
                    state_d = ST_XFER;
                    op_d    = OP_READ;
                    poll_d  = 1'b1;
                    cs_d    = 1'b1;
                end
            end
            ST_XFER: begin
                case (op_q)
                    OP_WRITE: shadow_d = avm.avm_writedata;
                    OP_SET:   shadow_d = ctrl_shadow | avm.avm_writedata;
                    OP_CLEAR: shadow_d = ctrl_shadow & ~avm.avm_writedata;
                    default:  ;
                endcase
                if (op_q == OP_READ) begin
                    state_d = ST_CAPT;
                end else begin
                    state_d = ST_DONE;
                    done_d  = gnt;
                end
            end
            ST_CAPT: begin
                state_d = ST_DONE;
                done_d  = gnt;
                if (poll_q) begin
                    status_d = avm.avm_readdata;
                    chg_d    = (avm.avm_readdata != status_q);
                end else begin
                    rdata_d = avm.avm_readdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            op_q               <= OP_WRITE;
            poll_q             <= 1'b0;
            gnt                <= '0;
            done               <= '0;
            rdata              <= '0;
            ctrl_shadow        <= '0;
            status_q           <= '0;
            status_chg         <= 1'b0;
            avm.avm_address    <= ADDR_DATA;
            avm.avm_chipselect <= 1'b0;
            avm.avm_write_n    <= 1'b1;
            avm.avm_writedata  <= '0;
        end else begin
            state              <= state_d;
            op_q               <= op_d;
            poll_q             <= poll_d;
            gnt                <= gnt_d;
            done               <= done_d;
            rdata              <= rdata_d;
            ctrl_shadow        <= shadow_d;
            status_q           <= status_d;
            status_chg         <= chg_d;
            avm.avm_address    <= addr_d;
            avm.avm_chipselect <= cs_d;
            avm.avm_write_n    <= wn_d;
            avm.avm_writedata  <= wd_d;
        end
    end

endmodule

// File: tb/tb_pio_ctrl_access_arbiter.sv
// Directed bench for pio_ctrl_access_arbiter with a behavioural PIO s1 slave.
// Build with +define+STATUS_POLL_EN to exercise background polling (POLL_DIV=16).
module tb_pio_ctrl_access_arbiter;
    import pio_arb_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      req_op;
    logic [DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt, done;
    logic [DATA_W-1:0]         rdata, ctrl_shadow, status_q;
    logic                      status_chg;
    logic [DATA_W-1:0]         pio_out = '0;
    logic [DATA_W-1:0]         in_port;
    int                        tests = 0;
    int                        fails = 0;

    pio_ctrl_access_arbiter_if #(.DATA_W(DATA_W)) avm ();

    pio_ctrl_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
`ifdef STATUS_POLL_EN
        ,
        .POLL_DIV(16)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_op      (req_op),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .rdata       (rdata),
        .ctrl_shadow (ctrl_shadow),
        .avm         (avm),
        .status_q    (status_q),
        .status_chg  (status_chg)
    );

    always #5 clk = ~clk;

    // PIO s1 model: data/set/clear writes, registered readdata of in_port.
    always @(posedge clk) begin
        if (avm.avm_chipselect && !avm.avm_write_n) begin
            case (avm.avm_address)
                3'd0:    pio_out <= avm.avm_writedata;
                3'd4:    pio_out <= pio_out | avm.avm_writedata;
                3'd5:    pio_out <= pio_out & ~avm.avm_writedata;
                default: ;
            endcase
        end
        avm.avm_readdata <= (avm.avm_chipselect && avm.avm_address == 3'd0) ? in_port : '0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400us");
        $fatal(1);
    end

    task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] d);
        req[r]              = 1'b1;
        req_op[2*r +: 2]    = op;
        req_wdata[32*r +: 32] = d;
    endtask

    // Waits (bounded) for any grant bit in mask; returns the number of negedges waited.
    task automatic wait_gnt(input logic [3:0] mask, output int cyc);
        cyc = 0;
        while ((gnt & mask) == 4'b0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if ((gnt & mask) == 4'b0) begin
            tests++; fails++;
            $display("FAIL wait_gnt: gnt=%b, required a bit of %b within 50 cycles", gnt, mask);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; req_op = '0; req_wdata = '0; in_port = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (gnt !== 4'b0 || done !== 4'b0) begin
            fails++; $display("FAIL reset_gnt_done: gnt=%b done=%b, required 0000 0000", gnt, done);
        end
        tests++;
        if (rdata !== 32'h0 || ctrl_shadow !== 32'h0 || status_q !== 32'h0 || status_chg !== 1'b0) begin
            fails++; $display("FAIL reset_regs: rdata=%h shadow=%h status=%h chg=%b, required all 0",
                              rdata, ctrl_shadow, status_q, status_chg);
        end
        tests++;
        if (avm.avm_chipselect !== 1'b0 || avm.avm_write_n !== 1'b1 || avm.avm_address !== 3'd0 ||
            avm.avm_writedata !== 32'h0) begin
            fails++; $display("FAIL reset_bus: cs=%b wn=%b addr=%0d wd=%h, required 0 1 0 0",
                              avm.avm_chipselect, avm.avm_write_n, avm.avm_address, avm.avm_writedata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int cyc;
        @(negedge clk); set_req(0, OP_WRITE, 32'hA5A5_0000); wait_gnt(4'b0001, cyc);
`ifndef STATUS_POLL_EN
        tests++;
        if (cyc != 1) begin fails++; $display("FAIL write_grant_latency: %0d cycles, required 1", cyc); end
`endif
        tests++;
        if (gnt !== 4'b0001 || done !== 4'b0 || avm.avm_chipselect !== 1'b1 || avm.avm_write_n !== 1'b0 ||
            avm.avm_address !== 3'd0 || avm.avm_writedata !== 32'hA5A5_0000) begin
            fails++; $display("FAIL write_xfer: gnt=%b done=%b cs=%b wn=%b addr=%0d wd=%h, required 0001 0000 1 0 0 a5a50000",
                              gnt, done, avm.avm_chipselect, avm.avm_write_n, avm.avm_address, avm.avm_writedata);
        end
        @(negedge clk); req[0] = 1'b0;
        tests++;
        if (done !== 4'b0001 || gnt !== 4'b0001 || avm.avm_chipselect !== 1'b0 || avm.avm_write_n !== 1'b1 ||
            ctrl_shadow !== 32'hA5A5_0000 || pio_out !== 32'hA5A5_0000) begin
            fails++; $display("FAIL write_done: done=%b gnt=%b cs=%b wn=%b shadow=%h pio=%h, required 0001 0001 0 1 a5a50000 a5a50000",
                              done, gnt, avm.avm_chipselect, avm.avm_write_n, ctrl_shadow, pio_out);
        end
        @(negedge clk);
        tests++;
        if (gnt !== 4'b0 || done !== 4'b0) begin
            fails++; $display("FAIL write_release: gnt=%b done=%b, required 0000 0000", gnt, done);
        end
    endtask

    task automatic test_set_clear();
        int cyc;
        @(negedge clk); set_req(1, OP_SET, 32'h0000_00FF); wait_gnt(4'b0010, cyc);
        tests++;
        if (avm.avm_address !== 3'd4 || avm.avm_write_n !== 1'b0 || avm.avm_writedata !== 32'h0000_00FF) begin
            fails++; $display("FAIL set_bus: addr=%0d wn=%b wd=%h, required 4 0 000000ff",
                              avm.avm_address, avm.avm_write_n, avm.avm_writedata);
        end
        @(negedge clk); req[1] = 1'b0;
        tests++;
        if (done !== 4'b0010 || ctrl_shadow !== 32'hA5A5_00FF) begin
            fails++; $display("FAIL set_done: done=%b shadow=%h, required 0010 a5a500ff", done, ctrl_shadow);
        end
        repeat (2) @(negedge clk);
        set_req(1, OP_CLEAR, 32'h0000_000F); wait_gnt(4'b0010, cyc);
        tests++;
        if (avm.avm_address !== 3'd5 || avm.avm_write_n !== 1'b0 || avm.avm_writedata !== 32'h0000_000F) begin
            fails++; $display("FAIL clear_bus: addr=%0d wn=%b wd=%h, required 5 0 0000000f",
                              avm.avm_address, avm.avm_write_n, avm.avm_writedata);
        end
        @(negedge clk); req[1] = 1'b0;
        tests++;
        if (done !== 4'b0010 || ctrl_shadow !== 32'hA5A5_00F0 || pio_out !== 32'hA5A5_00F0) begin
            fails++; $display("FAIL clear_done: done=%b shadow=%h pio=%h, required 0010 a5a500f0 a5a500f0",
                              done, ctrl_shadow, pio_out);
        end
        @(negedge clk);
    endtask

    task automatic test_read();
        int cyc;
        in_port = 32'h1234_5678;
        @(negedge clk); set_req(2, OP_READ, 32'hFFFF_FFFF); wait_gnt(4'b0100, cyc);
        tests++;
        if (avm.avm_chipselect !== 1'b1 || avm.avm_write_n !== 1'b1 || avm.avm_address !== 3'd0) begin
            fails++; $display("FAIL read_xfer: cs=%b wn=%b addr=%0d, required 1 1 0",
                              avm.avm_chipselect, avm.avm_write_n, avm.avm_address);
        end
        @(negedge clk); req[2] = 1'b0;
        tests++;
        if (done !== 4'b0 || avm.avm_chipselect !== 1'b0) begin
            fails++; $display("FAIL read_capt: done=%b cs=%b, required 0000 0", done, avm.avm_chipselect);
        end
        @(negedge clk);
        tests++;
        if (done !== 4'b0100 || rdata !== 32'h1234_5678 || ctrl_shadow !== 32'hA5A5_00F0) begin
            fails++; $display("FAIL read_done: done=%b rdata=%h shadow=%h, required 0100 12345678 a5a500f0",
                              done, rdata, ctrl_shadow);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int cyc;
        int dones = 0;
        @(negedge clk); set_req(0, OP_READ, 32'h0); wait_gnt(4'b0001, cyc);
        reset_n = 1'b0; req = '0;
        #1;
        tests++;
        if (gnt !== 4'b0 || done !== 4'b0 || rdata !== 32'h0 || ctrl_shadow !== 32'h0 ||
            avm.avm_chipselect !== 1'b0 || avm.avm_write_n !== 1'b1 || avm.avm_address !== 3'd0) begin
            fails++; $display("FAIL midop_reset: gnt=%b done=%b rdata=%h shadow=%h cs=%b wn=%b addr=%0d, required all reset values",
                              gnt, done, rdata, ctrl_shadow, avm.avm_chipselect, avm.avm_write_n, avm.avm_address);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) reset_n = 1'b1;
            if (done !== 4'b0) dones++;
        end
        tests++;
        if (dones != 0) begin fails++; $display("FAIL midop_no_done: %0d done cycles, required 0", dones); end
        set_req(1, OP_WRITE, 32'h11); set_req(3, OP_WRITE, 32'h33);
        wait_gnt(4'b1010, cyc);
        tests++;
        if (gnt !== 4'b0010) begin fails++; $display("FAIL midop_rr_ptr: gnt=%b, required 0010", gnt); end
        req[1] = 1'b0;
        wait_gnt(4'b1000, cyc);
        req[3] = 1'b0;
        tests++;
        if (gnt !== 4'b1000) begin fails++; $display("FAIL midop_next: gnt=%b, required 1000", gnt); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rr_all();
        int order[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        int viol = 0;
        int cyc = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, OP_WRITE, 32'h100 + i);
        while (n < 5 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (!$onehot0(gnt)) viol++;
            if (done != 4'b0) begin
                if (!$onehot(done)) viol++;
                order[n] = $clog2(done);
                tests++;
                if (ctrl_shadow !== 32'h100 + $clog2(done)) begin
                    fails++; $display("FAIL rr_shadow[%0d]: shadow=%h, required %h", n, ctrl_shadow, 32'h100 + $clog2(done));
                end
                n++;
            end
        end
        req = '0;
        tests++;
        if (n != 5 || viol != 0) begin
            fails++; $display("FAIL rr_count: dones=%0d onehot_violations=%0d, required 5 0", n, viol);
        end
        for (int k = 0; k < n; k++) begin
            tests++;
            if (order[k] != exp_order[k]) begin
                fails++; $display("FAIL rr_order[%0d]: got r%0d, required r%0d", k, order[k], exp_order[k]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef STATUS_POLL_EN
    task automatic test_poll();
        int cyc = 0;
        int chg = 0;
        int held_bad = 0;
        int dn = 0;
        in_port = 32'h0;
        while (status_q !== 32'h0 && cyc < 80) begin @(negedge clk); cyc++; end
        tests++;
        if (status_q !== 32'h0) begin fails++; $display("FAIL poll_zero: status_q=%h, required 0", status_q); end
        in_port = 32'h1;
        for (int i = 0; i < 60; i++) begin @(negedge clk); if (status_chg === 1'b1) chg++; end
        tests++;
        if (status_q !== 32'h1 || chg != 1) begin
            fails++; $display("FAIL poll_change: status_q=%h chg_pulses=%0d, required 1 1", status_q, chg);
        end
        set_req(2, OP_READ, 32'h0); wait_gnt(4'b0100, cyc);
        in_port = 32'h2;
        cyc = 0;
        while (dn < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (status_q !== 32'h1 || status_chg !== 1'b0) held_bad++;
            if (done[2] === 1'b1) dn++;
        end
        req[2] = 1'b0;
        tests++;
        if (held_bad != 0 || dn != 8 || rdata !== 32'h2) begin
            fails++; $display("FAIL poll_holdoff: bad_cycles=%0d dones=%0d rdata=%h, required 0 8 00000002", held_bad, dn, rdata);
        end
        cyc = 0;
        while (status_chg !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        tests++;
        if (status_q !== 32'h2 || cyc > 6) begin
            fails++; $display("FAIL poll_after_done: status_q=%h after %0d cycles, required 2 within 6", status_q, cyc);
        end
    endtask
`else
    task automatic test_no_poll();
        int chg = 0;
        in_port = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (status_chg !== 1'b0) chg++; end
        tests++;
        if (status_q !== 32'h0 || chg != 0) begin
            fails++; $display("FAIL no_poll: status_q=%h chg_cycles=%0d, required 0 0", status_q, chg);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_set_clear();
        test_read();
        test_reset_midop();
        test_rr_all();
`ifdef STATUS_POLL_EN
        test_poll();
`else
        test_no_poll();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
